// File: rtl/duck_pkg.sv
// Shared types for the duck ALU: opcode encoding, flag bit positions and
// sequencer states.
package duck_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'h0,
    OP_ADC   = 4'h1,
    OP_SUB   = 4'h2,
    OP_SBC   = 4'h3,
    OP_AND   = 4'h4,
    OP_OR    = 4'h5,
    OP_XOR   = 4'h6,
    OP_SHL   = 4'h7,
    OP_SHR   = 4'h8,
    OP_ROL   = 4'h9,
    OP_ROR   = 4'hA,
    OP_PASSB = 4'hB,
    OP_MUL   = 4'hC
  } op_e;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_e;

endpackage

// File: rtl/duck_mul_serial.sv
// Serial shift-add multiplier: one partial product per cycle, WIDTH cycles.
// done and product are combinational so the caller can capture on the final edge.
module duck_mul_serial #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [CW-1:0]    count;
  logic             busy;

  logic [WIDTH:0]   step_sum;
  logic [WIDTH-1:0] hi_next;
  logic [WIDTH-1:0] lo_next;

  // {hi,lo} shifts right each step; lo starts as the multiplier and is
  // consumed from its LSB while product bits fill in from the top.
  always_comb begin
    step_sum = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
    hi_next  = step_sum[WIDTH:1];
    lo_next  = {step_sum[0], lo[WIDTH-1:1]};
  end

  assign done    = busy && (count == LAST);
  assign product = {hi_next, lo_next};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand <= '0;
      hi    <= '0;
      lo    <= '0;
      count <= '0;
      busy  <= 1'b0;
    end else if (start) begin
      mcand <= a;
      hi    <= '0;
      lo    <= b;
      count <= '0;
      busy  <= 1'b1;
    end else if (busy) begin
      hi    <= hi_next;
      lo    <= lo_next;
      count <= count + 1'b1;
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/duck_alu_seq.sv
// Registered multi-op ALU with persistent carry, Z/N/C/V flags and an optional
// serial multiplier, handshaked on both command and result sides.
module duck_alu_seq
  import duck_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int MUL_EN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic [3:0]       flags,
  output logic             out_err
);

  // Handshake: a command transfers on a rising edge with in_valid && in_ready;
  // a result transfers on a rising edge with out_valid && out_ready, and is
  // held unchanged while out_valid && !out_ready.

  state_e state, state_n;
  logic   carry_q;
  logic   accept;

  logic [WIDTH-1:0]   b_op;
  logic               cin;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   alu_res;
  logic               c_new;
  logic               c_wr;
  logic               v_new;
  logic               illegal;
  logic               mul_start;
  logic [3:0]         alu_flags;

  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;

  assign in_ready = rst_n && (state == IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // Subtraction is a + ~b + cin, so C=1 means no borrow.
  always_comb begin
    b_op = b;
    cin  = 1'b0;
    case (op_e'(op))
      OP_ADC:  cin = carry_q;
      OP_SUB:  begin b_op = ~b; cin = 1'b1;    end
      OP_SBC:  begin b_op = ~b; cin = carry_q; end
      default: ;
    endcase
    sum = {1'b0, a} + {1'b0, b_op} + {{WIDTH{1'b0}}, cin};
  end

  always_comb begin
    alu_res   = '0;
    c_new     = carry_q;
    c_wr      = 1'b0;
    v_new     = 1'b0;
    illegal   = 1'b0;
    mul_start = 1'b0;
    case (op_e'(op))
      OP_ADD, OP_ADC, OP_SUB, OP_SBC: begin
        alu_res = sum[WIDTH-1:0];
        c_new   = sum[WIDTH];
        c_wr    = 1'b1;
        v_new   = (a[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:   alu_res = a & b;
      OP_OR:    alu_res = a | b;
      OP_XOR:   alu_res = a ^ b;
      OP_SHL:   begin alu_res = {a[WIDTH-2:0], 1'b0};    c_new = a[WIDTH-1]; c_wr = 1'b1; end
      OP_SHR:   begin alu_res = {1'b0, a[WIDTH-1:1]};    c_new = a[0];       c_wr = 1'b1; end
      OP_ROL:   begin alu_res = {a[WIDTH-2:0], carry_q}; c_new = a[WIDTH-1]; c_wr = 1'b1; end
      OP_ROR:   begin alu_res = {carry_q, a[WIDTH-1:1]}; c_new = a[0];       c_wr = 1'b1; end
      OP_PASSB: alu_res = b;
      OP_MUL: begin
        if (MUL_EN != 0) mul_start = accept;
        else             illegal   = 1'b1;
      end
      default:  illegal = 1'b1;
    endcase
    alu_flags         = '0;
    alu_flags[FLAG_Z] = (alu_res == '0);
    alu_flags[FLAG_N] = alu_res[WIDTH-1];
    alu_flags[FLAG_C] = c_new;
    alu_flags[FLAG_V] = v_new;
  end

  generate
    if (MUL_EN != 0) begin : g_mul
      duck_mul_serial #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (mul_product)
      );
    end else begin : g_no_mul
      assign mul_done    = 1'b0;
      assign mul_product = '0;
    end
  endgenerate

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (mul_start) state_n = MUL;
      MUL:     if (mul_done)  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      result_hi <= '0;
      flags     <= '0;
      out_err   <= 1'b0;
    end else if (accept && !mul_start) begin
      out_valid <= 1'b1;
      result    <= alu_res;
      result_hi <= '0;
      out_err   <= illegal;
      if (!illegal) flags <= alu_flags;
    end else if ((state == MUL) && mul_done) begin
      out_valid     <= 1'b1;
      result        <= mul_product[WIDTH-1:0];
      result_hi     <= mul_product[2*WIDTH-1:WIDTH];
      out_err       <= 1'b0;
      flags[FLAG_Z] <= (mul_product == '0);
      flags[FLAG_N] <= mul_product[2*WIDTH-1];
      flags[FLAG_C] <= carry_q;
      flags[FLAG_V] <= 1'b0;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // An accepted carry-writing op takes priority over a coincident clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           carry_q <= 1'b0;
    else if (accept && c_wr)              carry_q <= c_new;
    else if (carry_clr && (state == IDLE)) carry_q <= 1'b0;
  end

endmodule
